// File: rtl/soc_run_ctrl_pkg.sv
// Shared types and constants for the SoC run controller: FSM states,
// status bit positions, the default tohost mailbox and the sequence-counter width.
package soc_run_ctrl_pkg;

  typedef enum logic [1:0] {
    HOLD    = 2'd0,
    RELEASE = 2'd1,
    RUN     = 2'd2,
    DONE    = 2'd3
  } run_state_e;

  localparam int ST_DONE    = 0;
  localparam int ST_PASS    = 1;
  localparam int ST_FAIL    = 2;
  localparam int ST_TIMEOUT = 3;
  localparam int ST_W       = 4;

  localparam logic [31:0] TOHOST_ADDR_DEFAULT = 32'h0000_1000;

  // The sequence counter only ever holds values up to max(RST_CYCLES, STAGGER)-1.
  function automatic int seq_cnt_w(input int rst_cycles, input int stagger);
    int span;
    span = (rst_cycles > stagger) ? rst_cycles : stagger;
    return (span < 2) ? 1 : $clog2(span);
  endfunction

endpackage

// File: rtl/run_rst_seq.sv
// Staggered reset-release sequencer: holds every domain in reset for RST_CYCLES,
// then releases domain i STAGGER cycles after domain i-1.
module run_rst_seq
  import soc_run_ctrl_pkg::*;
#(
  parameter int N_DOMAINS  = 2,
  parameter int RST_CYCLES = 5,
  parameter int STAGGER    = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr_i,
  input  logic                 en_i,
  output logic                 hold_done_o,
  output logic                 seq_done_o,
  output logic [N_DOMAINS-1:0] dom_rst_o
);

  localparam int CW = seq_cnt_w(RST_CYCLES, STAGGER);
  localparam int IW = (N_DOMAINS > 1) ? $clog2(N_DOMAINS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(N_DOMAINS - 1);
  localparam logic [CW-1:0] HOLD_LIM = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] STAG_LIM = CW'((STAGGER > 0) ? STAGGER - 1 : 0);

  logic [CW-1:0]        cnt_q, cnt_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [N_DOMAINS-1:0] dom_rst_q, dom_rst_d;
  logic                 at_limit;

  always_comb begin
    at_limit    = (idx_q == '0) ? (cnt_q == HOLD_LIM) : (cnt_q == STAG_LIM);
    hold_done_o = en_i && at_limit && (idx_q == '0);
    seq_done_o  = en_i && at_limit && ((STAGGER == 0) || (idx_q == LAST_IDX));
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    dom_rst_d   = dom_rst_q;
    if (clr_i) begin
      cnt_d     = '0;
      idx_d     = '0;
      dom_rst_d = '1;
    end else if (en_i) begin
      if (!at_limit) begin
        cnt_d = cnt_q + 1'b1;
      end else begin
        cnt_d = '0;
        // The final step clears everything at once, which also covers STAGGER==0.
        if (seq_done_o) begin
          dom_rst_d = '0;
        end else begin
          dom_rst_d[idx_q] = 1'b0;
          idx_d            = idx_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      idx_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
    end
  end

  for (genvar gi = 0; gi < N_DOMAINS; gi++) begin : g_dom
    always_ff @(posedge clk or posedge rst) begin
      if (rst) dom_rst_q[gi] <= 1'b1;
      else     dom_rst_q[gi] <= dom_rst_d[gi];
    end
  end

  assign dom_rst_o = dom_rst_q;

endmodule

// File: rtl/soc_run_ctrl.sv
// SoC run controller: staggered domain reset release, run-cycle counting, tohost
// completion snoop and watchdog. RUN_CTRL_KICK_WDOG_EN selects a kick-based idle watchdog.
module soc_run_ctrl
  import soc_run_ctrl_pkg::*;
#(
  parameter int                N_DOMAINS      = 2,
  parameter int                RST_CYCLES     = 5,
  parameter int                STAGGER        = 4,
  parameter int                TIMEOUT_CYCLES = 2100,
  parameter int                CNT_W          = 32,
  parameter int                ADDR_W         = 32,
  parameter logic [ADDR_W-1:0] TOHOST_ADDR    = ADDR_W'(TOHOST_ADDR_DEFAULT)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sw_rst_req,
  input  logic                 mem_wr_en,
  input  logic [ADDR_W-1:0]    mem_wr_addr,
  input  logic [31:0]          mem_wr_data,
`ifdef RUN_CTRL_KICK_WDOG_EN
  input  logic                 wdog_kick,
`endif
  output logic [N_DOMAINS-1:0] dom_rst,
  output logic                 run_active,
  output logic                 done,
  output logic                 pass,
  output logic                 fail,
  output logic                 timeout,
  output logic [30:0]          exit_code,
  output logic [CNT_W-1:0]     cycle_count
);

  run_state_e       state_q, state_d;
  logic [ST_W-1:0]  status_q, status_d;
  logic [30:0]      exit_code_q, exit_code_d;
  logic [CNT_W-1:0] cycle_q, cycle_d;
  logic             run_active_q;
  logic             seq_en, seq_clr, hold_done, seq_done, tohost_hit, wdog_expired;

  run_rst_seq #(
    .N_DOMAINS  (N_DOMAINS),
    .RST_CYCLES (RST_CYCLES),
    .STAGGER    (STAGGER)
  ) u_seq (
    .clk         (clk),
    .rst         (rst),
    .clr_i       (seq_clr),
    .en_i        (seq_en),
    .hold_done_o (hold_done),
    .seq_done_o  (seq_done),
    .dom_rst_o   (dom_rst)
  );

`ifdef RUN_CTRL_KICK_WDOG_EN
  logic [CNT_W-1:0] idle_q, idle_d;

  always_comb begin
    idle_d = idle_q;
    if (sw_rst_req || state_q != RUN || wdog_kick) idle_d = '0;
    else if (idle_q != '1)                          idle_d = idle_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) idle_q <= '0;
    else     idle_q <= idle_d;
  end

  assign wdog_expired = !wdog_kick && (idle_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign wdog_expired = (cycle_q == CNT_W'(TIMEOUT_CYCLES - 1));
`endif

  // Even tohost values are console bytes, not completion.
  assign tohost_hit = mem_wr_en && (mem_wr_addr == TOHOST_ADDR) && mem_wr_data[0];

  always_comb begin
    state_d     = state_q;
    status_d    = status_q;
    exit_code_d = exit_code_q;
    cycle_d     = cycle_q;
    seq_en      = 1'b0;
    case (state_q)
      HOLD: begin
        seq_en = 1'b1;
        if (seq_done)       state_d = RUN;
        else if (hold_done) state_d = RELEASE;
      end
      RELEASE: begin
        seq_en = 1'b1;
        if (seq_done) state_d = RUN;
      end
      RUN: begin
        if (cycle_q != '1) cycle_d = cycle_q + 1'b1;
        if (tohost_hit) begin
          state_d            = DONE;
          status_d[ST_DONE]  = 1'b1;
          status_d[ST_PASS]  = (mem_wr_data == 32'd1);
          status_d[ST_FAIL]  = (mem_wr_data != 32'd1);
          exit_code_d        = mem_wr_data[31:1];
        end else if (wdog_expired) begin
          state_d              = DONE;
          status_d[ST_DONE]    = 1'b1;
          status_d[ST_TIMEOUT] = 1'b1;
        end
      end
      DONE: begin
      end
      default: state_d = HOLD;
    endcase
    if (sw_rst_req) begin
      state_d     = HOLD;
      status_d    = '0;
      exit_code_d = '0;
      cycle_d     = '0;
      seq_en      = 1'b0;
    end
  end

  // Entering or sitting in DONE keeps every domain frozen in reset.
  assign seq_clr = sw_rst_req || (state_d == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= HOLD;
      status_q     <= '0;
      exit_code_q  <= '0;
      cycle_q      <= '0;
      run_active_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      status_q     <= status_d;
      exit_code_q  <= exit_code_d;
      cycle_q      <= cycle_d;
      run_active_q <= (state_d == RUN);
    end
  end

  assign run_active  = run_active_q;
  assign done        = status_q[ST_DONE];
  assign pass        = status_q[ST_PASS];
  assign fail        = status_q[ST_FAIL];
  assign timeout     = status_q[ST_TIMEOUT];
  assign exit_code   = exit_code_q;
  assign cycle_count = cycle_q;

endmodule

// File: tb/tb_soc_run_ctrl.sv
// Scoreboard bench for soc_run_ctrl: expected output events are queued from a
// timeline model of the controller and checked by a monitor on every output change.
module tb_soc_run_ctrl;

  localparam int N     = 2;
  localparam int RSTC  = 5;
  localparam int STG   = 4;
`ifdef RUN_CTRL_KICK_WDOG_EN
  localparam int TO    = 50;
`else
  localparam int TO    = 2100;
`endif
  localparam int RUN_E = RSTC + (N - 1) * STG;
  localparam logic [31:0] TOHOST = 32'h0000_1000;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          sw_rst_req = 1'b0;
  logic          mem_wr_en = 1'b0;
  logic [31:0]   mem_wr_addr = '0;
  logic [31:0]   mem_wr_data = '0;
`ifdef RUN_CTRL_KICK_WDOG_EN
  logic          wdog_kick = 1'b0;
`endif
  logic [N-1:0]  dom_rst;
  logic          run_active, done, pass, fail, timeout;
  logic [30:0]   exit_code;
  logic [31:0]   cycle_count;

  typedef struct {
    int          edge_no;
    logic [N-1:0] dom;
    logic        ra, dn, ps, fl, to;
    logic [30:0] ec;
    logic [31:0] cc;
  } ev_t;

  typedef struct {
    int          cyc;
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  ev_t exp_q[$];
  wr_t wr_q[$];
  int  checks = 0;
  int  failures = 0;
  int  edge_no = 0;
  int  n_ev = 0;

  soc_run_ctrl #(
    .N_DOMAINS      (N),
    .RST_CYCLES     (RSTC),
    .STAGGER        (STG),
    .TIMEOUT_CYCLES (TO),
    .CNT_W          (32),
    .ADDR_W         (32),
    .TOHOST_ADDR    (TOHOST)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .sw_rst_req  (sw_rst_req),
    .mem_wr_en   (mem_wr_en),
    .mem_wr_addr (mem_wr_addr),
    .mem_wr_data (mem_wr_data),
`ifdef RUN_CTRL_KICK_WDOG_EN
    .wdog_kick   (wdog_kick),
`endif
    .dom_rst     (dom_rst),
    .run_active  (run_active),
    .done        (done),
    .pass        (pass),
    .fail        (fail),
    .timeout     (timeout),
    .exit_code   (exit_code),
    .cycle_count (cycle_count)
  );

  always #5 clk = ~clk;

  // Edge 1 is the first rising edge after rst or a soft-reset request.
  always @(posedge clk) begin
    if (rst || sw_rst_req) edge_no <= 0;
    else                   edge_no <= edge_no + 1;
  end

  function automatic void push_ev(input int e, input logic [N-1:0] d, input logic ra,
                                  input logic dn, input logic ps, input logic fl,
                                  input logic to, input logic [30:0] ec, input logic [31:0] cc);
    ev_t v;
    v.edge_no = e; v.dom = d; v.ra = ra; v.dn = dn; v.ps = ps; v.fl = fl;
    v.to = to; v.ec = ec; v.cc = cc;
    exp_q.push_back(v);
  endfunction

  // Domain i leaves reset at edge RSTC + i*STG; RUN starts with the last one.
  function automatic void push_release();
    logic [N-1:0] d;
    for (int i = 0; i < N; i++) begin
      d = '1;
      d = d << (i + 1);
      push_ev(RSTC + i * STG, d, (i == N - 1), 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    end
  endfunction

  function automatic void add_wr(input int c, input logic [31:0] a, input logic [31:0] d);
    wr_t w;
    w.cyc = c; w.addr = a; w.data = d;
    wr_q.push_back(w);
  endfunction

  // First odd tohost write no later than cycle TO-1 completes the run; otherwise timeout.
  function automatic void push_outcome();
    int          c;
    logic        hit;
    logic [31:0] d;
    c = TO - 1; hit = 1'b0; d = '0;
    foreach (wr_q[i]) begin
      if (!hit && wr_q[i].cyc <= TO - 1 && wr_q[i].addr == TOHOST && wr_q[i].data[0]) begin
        hit = 1'b1; c = wr_q[i].cyc; d = wr_q[i].data;
      end
    end
    push_ev(RUN_E + c + 1, '1, 1'b0, 1'b1, hit && (d == 32'd1), hit && (d != 32'd1),
            !hit, hit ? d[31:1] : 31'd0, 32'(c + 1));
  endfunction

  task automatic wait_edge(input int target);
    int guard;
    guard = 0;
    while (edge_no < target && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    if (edge_no != target) begin
      checks++; failures++;
      $display("FAIL schedule got_edge=%0d req_edge=%0d", edge_no, target);
    end
  endtask

  task automatic drive_wr(input int at_edge, input logic [31:0] a, input logic [31:0] d);
    wait_edge(at_edge);
    mem_wr_en = 1'b1; mem_wr_addr = a; mem_wr_data = d;
    @(negedge clk);
    mem_wr_en = 1'b0; mem_wr_addr = '0; mem_wr_data = '0;
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++; failures++;
      $display("FAIL drain pending=%0d req=0 edge=%0d", exp_q.size(), edge_no);
      exp_q.delete();
    end
  endtask

  task automatic restart_sw();
    push_ev(0, '1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    push_release();
    sw_rst_req = 1'b1;
    @(negedge clk);
    sw_rst_req = 1'b0;
  endtask

  task automatic run_scenario();
    push_outcome();
    foreach (wr_q[i]) drive_wr(RUN_E + wr_q[i].cyc, wr_q[i].addr, wr_q[i].data);
    wait_drain(TO + 200);
    wr_q.delete();
  endtask

  // Monitor: every change of {dom_rst, run_active, done} is one transaction.
  initial begin
    logic [N+1:0] prev;
    ev_t          e;
    prev = 'x;
    forever begin
      @(negedge clk);
      if ({dom_rst, run_active, done} !== prev) begin
        prev = {dom_rst, run_active, done};
        n_ev++;
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_ev%0d got dom=%b ra=%b done=%b edge=%0d", n_ev, dom_rst,
                   run_active, done, edge_no);
        end else begin
          e = exp_q.pop_front();
          if (!((e.edge_no < 0) || (e.edge_no == edge_no)) || dom_rst !== e.dom ||
              run_active !== e.ra || done !== e.dn || pass !== e.ps || fail !== e.fl ||
              timeout !== e.to || exit_code !== e.ec || cycle_count !== e.cc) begin
            failures++;
            $display("FAIL ev%0d got edge=%0d dom=%b ra=%b dn=%b ps=%b fl=%b to=%b ec=%0d cc=%0d req edge=%0d dom=%b ra=%b dn=%b ps=%b fl=%b to=%b ec=%0d cc=%0d",
                     n_ev, edge_no, dom_rst, run_active, done, pass, fail, timeout, exit_code,
                     cycle_count, e.edge_no, e.dom, e.ra, e.dn, e.ps, e.fl, e.to, e.ec, e.cc);
          end else begin
            $display("ev%0d ok edge=%0d dom=%b ra=%b dn=%b ps=%b fl=%b to=%b ec=%0d cc=%0d",
                     n_ev, edge_no, dom_rst, run_active, done, pass, fail, timeout,
                     exit_code, cycle_count);
          end
        end
      end
    end
  end

  initial begin
    repeat (50000) @(posedge clk);
    $display("FAIL global_time_limit edge=%0d pending=%0d", edge_no, exp_q.size());
    $fatal(1, "time limit");
  end

  initial begin
    int          c1, c2;
    logic [31:0] d;

    // Reset state, then the initial staggered release.
    push_ev(-1, '1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    repeat (5) @(posedge clk);
    @(negedge clk);
    push_release();
    rst = 1'b0;

    // Pass, with an odd write to a neighbouring address that must be ignored.
    c1 = (100 < TO - 1) ? 100 : TO / 2;
    add_wr(c1 - 20, TOHOST + 32'd4, 32'd1);
    add_wr(c1, TOHOST, 32'd1);
    run_scenario();

    // Even console byte ignored, then an odd failure code.
    restart_sw();
    c1 = $urandom_range(20, 5);
    c2 = c1 + $urandom_range(20, 1);
    d  = $urandom() | 32'h1;
    if (d == 32'd1) d = 32'd7;
    add_wr(c1, TOHOST, 32'h42);
    add_wr(c2, TOHOST, d);
    run_scenario();

    // No completion: watchdog.
    restart_sw();
    run_scenario();

    // Completion on the watchdog cycle wins.
    restart_sw();
    add_wr(TO - 1, TOHOST, 32'd1);
    run_scenario();

    // Async reset mid-RUN, tohost writes during HOLD/RELEASE ignored, then a random finish.
    restart_sw();
    c1 = $urandom_range(30, 10);
    wait_edge(RUN_E + c1);
    push_ev(-1, '1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    push_release();
    rst = 1'b0;
    drive_wr(1, TOHOST, 32'd1);
    drive_wr(RSTC + 1, TOHOST, 32'd3);
    d = $urandom() | 32'h1;
    if ($urandom_range(1, 0) == 0) d = 32'd1;
    add_wr($urandom_range(40, 5), TOHOST, d);
    run_scenario();

`ifdef RUN_CTRL_KICK_WDOG_EN
    // Kicks every 40 RUN cycles up to cycle 999, then silence until the idle watchdog fires.
    restart_sw();
    push_ev(RUN_E + 1000 + TO, '1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, '0, 32'(1000 + TO));
    for (int j = 1; j <= 25; j++) begin
      wait_edge(RUN_E + 40 * j - 1);
      wdog_kick = 1'b1;
      @(negedge clk);
      wdog_kick = 1'b0;
    end
    wait_drain(TO + 200);
`endif

    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL final_queue pending=%0d req=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
